deb_arbiter: RTL and testbench

//  Debounces NUM_BTNS active-low push buttons using one shared debounce timer.

---
 rtl/deb_pkg.sv | 14 +
 rtl/btn_sync.sv | 26 ++
 rtl/deb_arbiter.sv | 138 +++++++++++++
 tb/tb_deb_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/deb_pkg.sv
// Shared encodings and defaults for the button debounce arbiter.
// No logic; state encodings and the default window length only.
// Backpressure: not applicable.
package deb_pkg;

  typedef enum logic [1:0] {
    DEB_IDLE = 2'd0,
    DEB_WAIT = 2'd1,
    DEB_EMIT = 2'd2
  } deb_state_t;

  localparam logic [31:0] DEB_MAX_BTN_COUNT = 32'd2000000;

endpackage

// File: rtl/btn_sync.sv
// Two-flop vector synchroniser for asynchronous button levels.
// Latency: 2 clk edges from input change to q.
// Backpressure: none; samples every cycle.
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // two-stage capture; reset value means "released"
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/deb_arbiter.sv
// Debounces NUM_BTNS active-low buttons with one shared, round-robin scheduled window timer.
// Latency: event valid MAX_BTN_COUNT+5 edges after the first edge sampling a press (idle arbiter).
// Backpressure: evt_valid/evt_idx hold until evt_ready; other presses stay pending meanwhile.
module deb_arbiter
  import deb_pkg::*;
#(
  parameter int          NUM_BTNS      = 4,
  parameter logic [31:0] MAX_BTN_COUNT = DEB_MAX_BTN_COUNT,
  parameter int          IDX_W         = $clog2(NUM_BTNS)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_BTNS-1:0] nbtn,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_idx,
  input  logic                evt_ready,
  output logic                busy
);

  logic [NUM_BTNS-1:0] btn_s;
  logic [NUM_BTNS-1:0] pending;
  logic [NUM_BTNS-1:0] armed;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] rearm;
  logic [NUM_BTNS-1:0] cur_mask;
  logic [NUM_BTNS-1:0] grant_mask;
  logic [1:0]          warm;
  logic                active;
  logic                grant;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    cur;
  logic [IDX_W-1:0]    last;
  logic [31:0]         count;
  deb_state_t          state;

  btn_sync #(.W(NUM_BTNS)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (~nbtn),
    .q    (btn_s)
  );

  // first requester at or after lst+1, wrapping; lst itself is checked last
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_BTNS-1:0] req,
                                               input logic [IDX_W-1:0]    lst);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    sel   = lst;
    found = 1'b0;
    for (int k = 1; k <= NUM_BTNS; k++) begin
      cand = IDX_W'((int'(lst) + k) % NUM_BTNS);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // per-button press/rearm decisions and the grant taken from IDLE
  always_comb begin
    active     = (state == DEB_WAIT) || (state == DEB_EMIT);
    cur_mask   = active ? (NUM_BTNS'(1) << cur) : '0;
    press      = armed & btn_s;
    // synchroniser outputs are reset values, not samples, for the first two edges;
    // rearming on them would make a button held through reset look released
    rearm      = warm[1] ? (~armed & ~pending & ~btn_s & ~cur_mask) : '0;
    grant      = (state == DEB_IDLE) && (|pending);
    pick       = rr_pick(pending, last);
    grant_mask = grant ? (NUM_BTNS'(1) << pick) : '0;
  end

  // press capture and rearm flags, running independently of the FSM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      warm    <= '0;
      pending <= '0;
      armed   <= '0;
    end else begin
      warm    <= {warm[0], 1'b1};
      pending <= (pending | press) & ~grant_mask;
      armed   <= (armed & ~press) | rearm;
    end
  end

  // scheduler FSM: grant one pending button, time its window, emit on a held press
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= DEB_IDLE;
      count     <= '0;
      cur       <= '0;
      last      <= IDX_W'(NUM_BTNS - 1);
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        DEB_IDLE: begin
          if (grant) begin
            cur   <= pick;
            last  <= pick;
            count <= '0;
            busy  <= 1'b1;
            state <= DEB_WAIT;
          end
        end
        DEB_WAIT: begin
          if (count == MAX_BTN_COUNT) begin
            if (btn_s[cur]) begin
              evt_valid <= 1'b1;
              evt_idx   <= cur;
              state     <= DEB_EMIT;
            end else begin
              busy  <= 1'b0;
              state <= DEB_IDLE;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        DEB_EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= DEB_IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= DEB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deb_arbiter.sv
// Scoreboard bench for deb_arbiter with a 4-button, 5-cycle window configuration.
// Expected events are queued at stimulus time; a negedge monitor checks them.
// Backpressure exercised by holding evt_ready low for 20 cycles.
module tb_deb_arbiter;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] nbtn;
  logic       evt_valid;
  logic [1:0] evt_idx;
  logic       evt_ready;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int idx;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t cur_e;
  logic prev_v  = 1'b0;
  logic prev_hs = 1'b0;

  deb_arbiter #(.NUM_BTNS(4), .MAX_BTN_COUNT(32'd4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .nbtn      (nbtn),
    .evt_valid (evt_valid),
    .evt_idx   (evt_idx),
    .evt_ready (evt_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // edge counter used for latency expectations
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int idx, input int at);
    exp_t e;
    e.idx = idx;
    e.at  = at;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: match each rising evt_valid against the queue, check hold and drop
  always @(negedge clk) begin
    if (!nrst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("valid_after_handshake", int'(evt_valid), 0);
      if (evt_valid && !prev_v) begin
        if (q.size() == 0) begin
          check("unexpected_evt", int'(evt_idx), -1);
          cur_e.idx = int'(evt_idx);
          cur_e.at  = -1;
        end else begin
          cur_e = q.pop_front();
          check("evt_idx", int'(evt_idx), cur_e.idx);
          if (cur_e.at >= 0) check("evt_cycle", cyc, cur_e.at);
        end
      end else if (evt_valid && prev_v && !prev_hs) begin
        check("evt_idx_stable", int'(evt_idx), cur_e.idx);
      end
      prev_v  = evt_valid;
      prev_hs = evt_valid && evt_ready;
    end
  end

  initial begin
    int c;
    int busy_cnt;
    nrst      = 1'b1;
    nbtn      = 4'hF;
    evt_ready = 1'b1;
    #2 nrst = 1'b0;
    #1;
    check("reset_valid", int'(evt_valid), 0);
    check("reset_idx",   int'(evt_idx),   0);
    check("reset_busy",  int'(busy),      0);
    tick(3);
    nrst = 1'b1;
    tick(5);

    // single press on button 0, held, then a second press after release
    c = cyc; expect_evt(0, c + 9); nbtn = 4'b1110;
    tick(20);
    nbtn = 4'hF; tick(5);
    c = cyc; expect_evt(0, c + 9); nbtn = 4'b1110;
    tick(15);
    nbtn = 4'hF; tick(5);

    // simultaneous 1 and 3 (last=0 -> 1 first), then 0 and 1 after last=3
    c = cyc; expect_evt(1, c + 9); expect_evt(3, c + 16); nbtn = 4'b0101;
    tick(30);
    nbtn = 4'hF; tick(5);
    c = cyc; expect_evt(0, c + 9); expect_evt(1, c + 16); nbtn = 4'b1100;
    tick(30);
    nbtn = 4'hF; tick(5);

    // back-pressure: event on 3 held for 20 cycles, button 1 pressed meanwhile
    evt_ready = 1'b0;
    c = cyc; expect_evt(3, c + 9); nbtn = 4'b0111;
    tick(12);
    nbtn = 4'b0101;
    tick(17);
    c = cyc; expect_evt(1, c + 7); evt_ready = 1'b1;
    tick(15);
    nbtn = 4'hF; tick(5);

    // glitch on button 2: three low cycles, no event, busy for exactly one window
    nbtn = 4'b1011;
    tick(3);
    nbtn = 4'hF;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, 5);
    tick(2);
    c = cyc; expect_evt(2, c + 9); nbtn = 4'b1011;
    tick(15);
    nbtn = 4'hF; tick(5);

    // button 3 held through reset: nothing until release and a new press
    nrst = 1'b0;
    #1;
    check("rst2_valid", int'(evt_valid), 0);
    nbtn = 4'b0111;
    tick(3);
    nrst = 1'b1;
    tick(30);
    nbtn = 4'hF; tick(5);
    c = cyc; expect_evt(3, c + 9); nbtn = 4'b0111;
    tick(15);
    nbtn = 4'hF; tick(5);

    // reset at count=2 of a window on button 0, button still held afterwards
    nbtn = 4'b1110;
    tick(6);
    check("midwait_busy", int'(busy), 1);
    nrst = 1'b0;
    #1;
    check("midwait_rst_valid", int'(evt_valid), 0);
    check("midwait_rst_idx",   int'(evt_idx),   0);
    check("midwait_rst_busy",  int'(busy),      0);
    tick(2);
    nrst = 1'b1;
    tick(30);
    check("midwait_no_busy", int'(busy), 0);
    nbtn = 4'hF; tick(5);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
